// File: rtl/shift_seq_pkg.sv
// Shared types for the shift/rotate sequencer: op codes,
// FSM states, direction values and the mode-switch decoder.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    OP_HOLD       = 2'b00,
    OP_SHIFT_ZERO = 2'b01,
    OP_SHIFT_FILL = 2'b10,
    OP_ROTATE     = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  localparam logic DIR_TOWARD_A = 1'b1;
  localparam logic DIR_TOWARD_D = 1'b0;

  typedef struct packed {
    op_e  op;
    logic illegal;
  } dec_t;

  function automatic dec_t decode_mode(
    input logic [2:0] sw
  );
    dec_t d;
    d.illegal = 1'b0;
    unique case (sw)
      3'b000:  d.op = OP_HOLD;
      3'b001:  d.op = OP_SHIFT_ZERO;
      3'b010:  d.op = OP_SHIFT_FILL;
      3'b100:  d.op = OP_ROTATE;
      default: begin
        d.op      = OP_HOLD;
        d.illegal = 1'b1;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Command handshake to the digit register datapath.
// master: cmd_valid/cmd_op/cmd_dir out, cmd_ready in.
interface shift_seq_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       cmd_dir;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_dir,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_dir,
    output cmd_ready
  );
endinterface

// File: rtl/shift_seq_ctrl_in_debounce.sv
// 2-flop synchroniser plus tick-qualified debounce per bit.
// Ports: clk, rst_n, tick, raw_i[WIDTH], deb_o[WIDTH].
module in_debounce #(
  parameter int WIDTH     = 5,
  parameter int DEB_TICKS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] deb_o
);

  localparam int CW = $clog2(DEB_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(DEB_TICKS - 1);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;
  logic [WIDTH-1:0] deb_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [CW-1:0] cnt_q;

    // Any return to agreement throws away partial progress,
    // so a glitch shorter than DEB_TICKS ticks never lands.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt_q    <= '0;
        deb_q[i] <= 1'b0;
      end else if (s2_q[i] == deb_q[i]) begin
        cnt_q <= '0;
      end else if (tick) begin
        if (cnt_q == LAST) begin
          cnt_q    <= '0;
          deb_q[i] <= s2_q[i];
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer: debounce, decode, trigger select, issue FSM.
// Ports: clk, rst_n, tick, switch, step_btn, run_en, cmd.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int DEB_TICKS = 4,
  parameter int CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic [3:0]         switch,
  input  logic               step_btn,
  input  logic               run_en,
  shift_seq_ctrl_if.master   cmd,
  output logic               illegal,
  output logic               overrun,
  output logic [CNT_W-1:0]   step_cnt
);

  logic [4:0] deb;

  in_debounce #(
    .WIDTH     (5),
    .DEB_TICKS (DEB_TICKS)
  ) u_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick),
    .raw_i ({step_btn, switch}),
    .deb_o (deb)
  );

  state_e     state_q;
  state_e     state_d;
  op_e        mode_q;
  logic       illegal_q;
  logic       btn_q;
  op_e        op_q;
  logic       dir_q;
  logic       overrun_q;
  logic [CNT_W-1:0] cnt_q;

  dec_t dec;
  logic step_edge;
  logic trig;
  logic valid;
  logic fire;
  logic accept;

  assign dec       = decode_mode(deb[2:0]);
  assign step_edge = deb[4] & ~btn_q;
  assign trig      = run_en ? tick : step_edge;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q    <= OP_HOLD;
      illegal_q <= 1'b0;
      btn_q     <= 1'b0;
    end else begin
      mode_q    <= dec.op;
      illegal_q <= dec.illegal;
      btn_q     <= deb[4];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (trig && mode_q != OP_HOLD)
          state_d = ST_ISSUE;
      ST_ISSUE:
        if (cmd.cmd_ready)
          state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    valid  = (state_q == ST_ISSUE);
    fire   = valid & cmd.cmd_ready;
    accept = ~valid & trig
           & (mode_q != OP_HOLD);
  end

  // op reads HOLD whenever no command is pending.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q      <= OP_HOLD;
      dir_q     <= DIR_TOWARD_D;
      overrun_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (accept) begin
        op_q  <= mode_q;
        dir_q <= deb[3];
      end else if (fire) begin
        op_q  <= OP_HOLD;
      end
      if (valid && trig)
        overrun_q <= 1'b1;
      if (fire)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cmd.cmd_valid = valid;
  assign cmd.cmd_op    = op_q;
  assign cmd.cmd_dir   = dir_q;
  assign illegal       = illegal_q;
  assign overrun       = overrun_q;
  assign step_cnt      = cnt_q;

endmodule
